// File: rtl/seq_hex_adder_pkg.sv
// Shared types, glyph constants and hex-to-segment decode for seq_hex_adder.
// Segments are active-low {g,f,e,d,c,b,a}.
package seq_hex_adder_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RESULT  = 2'b10
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_hex_adder_dec.sv
// Single-nibble 7-segment decoder, one instance per displayed hex digit.
module hex7seg_dec
  import seq_hex_adder_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/seq_hex_adder.sv
// Keyed multi-digit hex adder: synchronised buttons, 3-state entry FSM, registered sum.
// Define SEQ_HEX_ADDER_SUB_EN to add the mode_sub input (A - B with borrow display).
module seq_hex_adder
  import seq_hex_adder_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            hex_in,
  input  logic [1:0]            btn_n,
`ifdef SEQ_HEX_ADDER_SUB_EN
  input  logic                  mode_sub,
`endif
  output logic [7*DIGITS-1:0]   a_seg,
  output logic [7*DIGITS-1:0]   b_seg,
  output logic [7*DIGITS-1:0]   sum_seg,
  output logic [6:0]            cout_seg,
  output logic [1:0]            state_led
);

  localparam int W = 4*DIGITS;

  logic [1:0] btn_s1_q, btn_s2_q, btn_e_q;
  logic       press_digit, press_next;

  // Edge register holds the previous synchronised level; a press is its 1->0 step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 2'b11;
      btn_s2_q <= 2'b11;
      btn_e_q  <= 2'b11;
    end else begin
      btn_s1_q <= btn_n;
      btn_s2_q <= btn_s1_q;
      btn_e_q  <= btn_s2_q;
    end
  end

  assign press_digit = btn_e_q[0] & ~btn_s2_q[0];
  assign press_next  = btn_e_q[1] & ~btn_s2_q[1];

  logic sub_sel;
`ifdef SEQ_HEX_ADDER_SUB_EN
  logic mode_s1_q, mode_s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
    end else begin
      mode_s1_q <= mode_sub;
      mode_s2_q <= mode_s1_q;
    end
  end
  assign sub_sel = mode_s2_q;
`else
  assign sub_sel = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic           cout_q, cout_d, sub_q, sub_d;
  logic [W:0]     sum_full;

  // Both operands zero-extended so the MSB is carry on add and borrow on subtract.
  assign sum_full = sub_sel ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    case (state_q)
      ENTER_A: begin
        if (press_next)       state_d = ENTER_B;
        else if (press_digit) a_d = W'({a_q, hex_in});
      end
      ENTER_B: begin
        if (press_next) begin
          state_d = RESULT;
          s_d     = sum_full[W-1:0];
          cout_d  = sum_full[W];
          sub_d   = sub_sel;
        end else if (press_digit) begin
          b_d = W'({b_q, hex_in});
        end
      end
      RESULT: begin
        if (press_next) begin
          state_d = ENTER_A;
          a_d     = '0;
          b_d     = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          sub_d   = 1'b0;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  logic [7*DIGITS-1:0] s_dig;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    hex7seg_dec u_a (.hex(a_q[4*d +: 4]), .seg(a_seg[7*d +: 7]));
    hex7seg_dec u_b (.hex(b_q[4*d +: 4]), .seg(b_seg[7*d +: 7]));
    hex7seg_dec u_s (.hex(s_q[4*d +: 4]), .seg(s_dig[7*d +: 7]));
  end

  always_comb begin
    sum_seg  = {DIGITS{SEG_DASH}};
    cout_seg = SEG_BLANK;
    if (state_q == RESULT) begin
      sum_seg = s_dig;
      if (sub_q) cout_seg = cout_q ? SEG_DASH : SEG_BLANK;
      else       cout_seg = cout_q ? SEG_ONE  : SEG_ZERO;
    end
  end

  assign state_led = state_q;

endmodule
